tns_rx_27: RTL and testbench
============================

TNS_RX_27 -- requirements
Module: tns_rx_27

Interface
REQ-001 Parameter: CNT_W, default 16, width of the saturating violation counter.
REQ-002 Port: clock  input  1  the single clock; all state updates on the rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: tsv_in  input  27  received TSV bus, 9 groups of 3; group j = tsv_in[3j+2:3j].
REQ-005 Port: tsv_valid  input  1  tsv_in carries a word this cycle.
REQ-006 Port: clear_err  input  1  one-cycle pulse; clears sticky flags and the counter.
REQ-007 Port: data_out  output  BLEN09  decoded binary word.
REQ-008 Port: data_valid  output  1  data_out and the per-word flags are valid this cycle.
REQ-009 Port: rule_err  output  1  the word on data_out violated the transition rule (per-word).
REQ-010 Port: range_err  output  1  the decoded value on data_out is >= TNS10_C (per-word).
REQ-011 Port: err_sticky  output  1  set by any rule_err or range_err; held until clear_err.
REQ-012 Port: err_count  output  CNT_W  number of words flagged with rule_err or range_err, saturating.

Function
REQ-013 Stage 1 SHALL register tsv_in and tsv_valid unconditionally each cycle.
REQ-014 Stage 2 SHALL decode the stage-1 word and register data_out, data_valid, rule_err and range_err.
REQ-015 Latency SHALL be exactly 2 cycles from tsv_valid to data_valid; throughput is 1 word/cycle, with no backpressure.
REQ-016 History register rbit[8:0] SHALL hold bit 3j+2 of the last valid word and SHALL update only on stage-1 valid words, including flagged words.
REQ-017 Violation for group j: the group bits (3j,3j+1,3j+2) = (0,0,1) while rbit[j]=0, or (1,1,0) while rbit[j]=1.
REQ-018 rule_err SHALL be the OR of the violations over all 9 groups, evaluated against rbit before it is updated by the same word.
REQ-019 Decoding SHALL be bit-exact with the existing combinational TNS decoder; data_out SHALL still be driven on a flagged word.
REQ-020 When data_valid=0, rule_err and range_err SHALL be 0 and data_out SHALL hold its last value.
REQ-021 err_count SHALL increment by 1 per flagged word and saturate at all-ones, with no wrap.
REQ-022 If clear_err and a flagged word occur in the same cycle, clear SHALL apply first, giving err_count=1 and err_sticky=1.
REQ-023 Idle cycles (tsv_valid=0) SHALL change neither rbit nor the error state.

Reset
REQ-024 On reset_n=0: both pipeline stages, data_out, all flags, err_count and rbit SHALL go to 0 immediately.
REQ-025 A reset during operation SHALL discard in-flight words; no data_valid is issued for them.
REQ-026 The first word after reset SHALL be checked against rbit=0, matching the transmitter reset state.

Configuration
REQ-027 Macro TNS_RX_ERRCNT_EN defined: err_count and its saturation logic SHALL be present.
REQ-028 Macro TNS_RX_ERRCNT_EN undefined: err_count SHALL be tied to 0 with no counter flops; err_sticky is unaffected.

Structure
REQ-029 Package tns_pkg SHALL hold TSV_W=27, GROUPS=9, BLEN09, TNS10_C, and typedefs tsv_word_t and tns_data_t.
REQ-030 The combinational decoder SHALL be one sub-module, tns_dec_27, instantiated in stage 2; rule and range checks stay in tns_rx_27.

Verification
REQ-031 Round trip: 10000 random values below TNS10_C through TNS_encoder_27 into tns_rx_27 -> data_out equals input delayed 2 cycles; err_count=0.
REQ-032 After reset, tsv_in=27'h0000004 (group 0 = 0,0,1) -> rule_err=1 two cycles later; err_count=1.
REQ-033 Next tsv_in=27'h0000003 (group 0 = 1,1,0, rbit[0]=1) -> rule_err=1; err_count=2.
REQ-034 A word decoding to TNS10_C -> range_err=1, rule_err=0; err_sticky=1.
REQ-035 Preload err_count to all-ones with flagged words, send one more -> stays all-ones; send clear_err together with a flagged word -> err_count=1.
REQ-036 Assert reset_n=0 with two words in flight -> all outputs 0 at once; no data_valid after release; the next word is checked against rbit=0.

Source files
------------

// File: rtl/tns_pkg.sv
// Shared types and constants for the 27-bit TSV receiver.
// Each 3-bit group carries one base-7 digit. Six digits use fixed codes;
// digit 6 has two codes (3'b011 / 3'b100) chosen by the transmitter so the
// group never produces a forbidden transition against its history bit.
package tns_pkg;

    localparam int TSV_W  = 27;
    localparam int GROUPS = 9;
    localparam int BLEN09 = 26;

    typedef logic [TSV_W-1:0]  tsv_word_t;
    typedef logic [BLEN09-1:0] tns_data_t;

    // Decoded values at or above this bound are out of range
    localparam tns_data_t TNS10_C = 26'd10_000_000;

    // Forbidden group codes (bit 3j+2 is the code MSB) for history bit 0 / 1
    localparam logic [2:0] VIOL_R0 = 3'b100;
    localparam logic [2:0] VIOL_R1 = 3'b011;

    // Map one group code to its base-7 digit
    function automatic logic [2:0] code_digit(input logic [2:0] code);
        logic [2:0] d;
        case (code)
            3'b000:  d = 3'd0;
            3'b001:  d = 3'd1;
            3'b010:  d = 3'd2;
            3'b011:  d = 3'd6;
            3'b100:  d = 3'd6;
            3'b101:  d = 3'd3;
            3'b110:  d = 3'd4;
            default: d = 3'd5;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tns_rx_27_if.sv
// Receiver bus: TSV input side, decoded output side and error reporting.
interface tns_rx_27_if
    import tns_pkg::*;
    #(parameter int CNT_W = 16) ();

    tsv_word_t        tsv_in;
    logic             tsv_valid;
    logic             clear_err;
    tns_data_t        data_out;
    logic             data_valid;
    logic             rule_err;
    logic             range_err;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;

    modport master (
        output tsv_in, tsv_valid, clear_err,
        input  data_out, data_valid, rule_err, range_err, err_sticky, err_count
    );

    modport slave (
        input  tsv_in, tsv_valid, clear_err,
        output data_out, data_valid, rule_err, range_err, err_sticky, err_count
    );

endinterface

// File: rtl/tns_dec_27.sv
// Combinational TNS decoder: nine base-7 digits, group 0 least significant.
module tns_dec_27
    import tns_pkg::*;
(
    input  tsv_word_t i_tsv,
    output tns_data_t o_data
);

    // Horner evaluation from the most significant group down
    always_comb begin
        o_data = '0;
        for (int j = GROUPS - 1; j >= 0; j--) begin
            o_data = (o_data * tns_data_t'(7)) + tns_data_t'(code_digit(i_tsv[3*j +: 3]));
        end
    end

endmodule

// File: rtl/tns_rx_27.sv
// TNS receiver: two-stage pipeline (capture, decode+check), per-group
// transition-rule checking against a history register, range checking,
// sticky error flag and an optional saturating error counter.
// Optional feature macro: TNS_RX_ERRCNT_EN (enables err_count).
module tns_rx_27
    import tns_pkg::*;
    #(parameter int CNT_W = 16)
(
    input logic         clock,
    input logic         reset_n,
    tns_rx_27_if.slave  bus
);

    tsv_word_t         r_tsv_p1;
    logic              r_vld_p1;
    tns_data_t         r_data_p2;
    logic              r_vld_p2;
    logic              r_rule_p2;
    logic              r_range_p2;
    logic [GROUPS-1:0] r_rbit;
    logic              r_sticky;

    tns_data_t         w_dec;
    logic [GROUPS-1:0] w_viol;
    logic [GROUPS-1:0] w_rbit_nxt;
    logic              w_rule;
    logic              w_range;
    logic              w_flag;

    // Stage 1: capture the bus every cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tsv_p1 <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_tsv_p1 <= bus.tsv_in;
            r_vld_p1 <= bus.tsv_valid;
        end
    end

    tns_dec_27 u_dec (
        .i_tsv  (r_tsv_p1),
        .o_data (w_dec)
    );

    // Per-group rule check against the pre-update history, and next history
    always_comb begin
        w_viol     = '0;
        w_rbit_nxt = '0;
        for (int j = 0; j < GROUPS; j++) begin
            w_viol[j]     = ((r_tsv_p1[3*j +: 3] == VIOL_R0) && !r_rbit[j]) ||
                            ((r_tsv_p1[3*j +: 3] == VIOL_R1) &&  r_rbit[j]);
            w_rbit_nxt[j] = r_tsv_p1[3*j + 2];
        end
    end

    assign w_rule  = r_vld_p1 & (|w_viol);
    assign w_range = r_vld_p1 & (w_dec >= TNS10_C);
    assign w_flag  = w_rule | w_range;

    // Stage 2: register decoded word and per-word flags; data holds when idle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data_p2  <= '0;
            r_vld_p2   <= 1'b0;
            r_rule_p2  <= 1'b0;
            r_range_p2 <= 1'b0;
        end else begin
            r_vld_p2   <= r_vld_p1;
            r_rule_p2  <= w_rule;
            r_range_p2 <= w_range;
            if (r_vld_p1) begin
                r_data_p2 <= w_dec;
            end
        end
    end

    // History bits follow every valid word, flagged or not
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rbit <= '0;
        end else if (r_vld_p1) begin
            r_rbit <= w_rbit_nxt;
        end
    end

    // Sticky flag: clear takes effect before a same-cycle flagged word sets it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky <= 1'b0;
        end else begin
            r_sticky <= (r_sticky & ~bus.clear_err) | w_flag;
        end
    end

`ifdef TNS_RX_ERRCNT_EN
    logic [CNT_W-1:0] r_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != '1)) begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return v;
    endfunction

    // Saturating count of flagged words; clear applies before the increment
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= sat_inc(bus.clear_err ? '0 : r_cnt, w_flag);
        end
    end

    assign bus.err_count = r_cnt;
`else
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    assign bus.err_count = CNT_ZERO;
`endif

    assign bus.data_out   = r_data_p2;
    assign bus.data_valid = r_vld_p2;
    assign bus.rule_err   = r_rule_p2;
    assign bus.range_err  = r_range_p2;
    assign bus.err_sticky = r_sticky;

endmodule

// File: tb/tb_tns_rx_27.sv
// Self-checking bench for tns_rx_27: behavioural model with per-cycle
// compare, transmitter-side encoder for round-trip traffic, directed cases.
module tb_tns_rx_27;
    import tns_pkg::*;

    localparam int     CW    = 4;
    localparam longint CMAX  = (64'd1 << CW) - 1;
    localparam longint LIMIT = 10_000_000;
`ifdef TNS_RX_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    // Digit carried by each 3-bit group code (code value = bits {3j+2,3j+1,3j})
    localparam int DIG [8] = '{0, 1, 2, 6, 6, 3, 4, 5};
    // Fixed transmit code for digits 0..5
    localparam int ENC [6] = '{0, 1, 2, 5, 6, 7};

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    tns_rx_27_if #(.CNT_W(CW)) bus ();

    tns_rx_27 #(.CNT_W(CW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: sum of digit * 7^j
    function automatic longint model_decode(input logic [26:0] w);
        longint v = 0;
        longint p = 1;
        for (int j = 0; j < 9; j++) begin
            v += longint'(DIG[w[3*j +: 3]]) * p;
            p *= 7;
        end
        return v;
    endfunction

    // Rule: tuple (b0,b1,b2) = (0,0,1) with history 0, or (1,1,0) with history 1
    function automatic bit model_viol(input logic [26:0] w, input bit [8:0] hist);
        bit b0, b1, b2;
        for (int j = 0; j < 9; j++) begin
            b0 = w[3*j];
            b1 = w[3*j+1];
            b2 = w[3*j+2];
            if (!hist[j] && !b0 && !b1 &&  b2) return 1'b1;
            if ( hist[j] &&  b0 &&  b1 && !b2) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Transmitter encoder: digit 6 uses the code that keeps the group's last bit
    function automatic logic [26:0] encode(input longint v, input bit [8:0] st);
        logic [26:0] w = '0;
        longint      r = v;
        int          d;
        for (int j = 0; j < 9; j++) begin
            d = int'(r % 7);
            r = r / 7;
            if (d == 6) w[3*j +: 3] = st[j] ? 3'b100 : 3'b011;
            else        w[3*j +: 3] = 3'(ENC[d]);
        end
        return w;
    endfunction

    // Model state
    bit          m_vld;
    logic [26:0] m_word;
    bit   [8:0]  m_hist;
    longint      e_data;
    bit          e_valid, e_rule, e_range, e_sticky;
    longint      e_cnt;

    bit     [8:0] enc_st;
    bit           rt_on = 1'b0;
    longint       rt_q[$];

    // Model update on every edge/reset, then compare all outputs
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_vld = 0; m_word = '0; m_hist = '0;
            e_data = 0; e_valid = 0; e_rule = 0; e_range = 0; e_sticky = 0; e_cnt = 0;
        end else begin
            e_valid = m_vld;
            e_rule  = 0;
            e_range = 0;
            if (bus.clear_err) begin
                e_sticky = 0;
                e_cnt    = 0;
            end
            if (m_vld) begin
                e_data  = model_decode(m_word);
                e_rule  = model_viol(m_word, m_hist);
                e_range = (e_data >= LIMIT);
                for (int j = 0; j < 9; j++) m_hist[j] = m_word[3*j+2];
                if (e_rule || e_range) begin
                    e_sticky = 1;
                    if (e_cnt < CMAX) e_cnt++;
                end
            end
            m_vld  = bus.tsv_valid;
            m_word = bus.tsv_in;
        end
        #1;
        check("data_out",   bus.data_out,   e_data);
        check("data_valid", bus.data_valid, e_valid);
        check("rule_err",   bus.rule_err,   e_rule);
        check("range_err",  bus.range_err,  e_range);
        check("err_sticky", bus.err_sticky, e_sticky);
        check("err_count",  bus.err_count,  CNT_EN ? e_cnt : 0);
        if (rt_on && bus.data_valid) begin
            if (rt_q.size() == 0) check("round_trip_queue", 1, 0);
            else                  check("round_trip", bus.data_out, rt_q.pop_front());
        end
    end

    task automatic send_word(input logic [26:0] w);
        @(negedge clock);
        bus.tsv_in    = w;
        bus.tsv_valid = 1'b1;
        for (int j = 0; j < 9; j++) enc_st[j] = w[3*j+2];
        @(negedge clock);
        bus.tsv_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        bus.clear_err = 1'b1;
        @(negedge clock);
        bus.clear_err = 1'b0;
    endtask

    initial begin
        logic [26:0] w;
        longint      v;

        bus.tsv_in    = '0;
        bus.tsv_valid = 1'b0;
        bus.clear_err = 1'b0;
        enc_st        = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        check("rst_data_valid", bus.data_valid, 0);
        check("rst_data_out",   bus.data_out,   0);
        check("rst_sticky",     bus.err_sticky, 0);
        check("rst_count",      bus.err_count,  0);

        // Group 0 = (0,0,1) against history 0
        send_word(27'h0000004);
        @(negedge clock);
        check("r032_rule",  bus.rule_err,  1);
        check("r032_range", bus.range_err, 0);
        check("r032_data",  bus.data_out,  6);
        check("r032_count", bus.err_count, CNT_EN ? 1 : 0);

        // Group 0 = (1,1,0) against history 1
        send_word(27'h0000003);
        @(negedge clock);
        check("r033_rule",  bus.rule_err,  1);
        check("r033_data",  bus.data_out,  6);
        check("r033_count", bus.err_count, CNT_EN ? 2 : 0);

        pulse_clear();
        check("clr_sticky", bus.err_sticky, 0);
        check("clr_count",  bus.err_count,  0);

        // Round trip with random idle gaps, boundary values first
        rt_on = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clock);
            if (i > 2 && $urandom_range(0, 3) == 0) begin
                bus.tsv_valid = 1'b0;
                i--;
            end else begin
                v = (i == 0) ? 0 : (i == 1) ? LIMIT - 1 : longint'($urandom_range(0, 9_999_999));
                w = encode(v, enc_st);
                rt_q.push_back(v);
                bus.tsv_in    = w;
                bus.tsv_valid = 1'b1;
                for (int j = 0; j < 9; j++) enc_st[j] = w[3*j+2];
            end
        end
        @(negedge clock);
        bus.tsv_valid = 1'b0;
        repeat (4) @(negedge clock);
        rt_on = 1'b0;
        check("rt_drained", rt_q.size(), 0);
        check("rt_count",   bus.err_count,  0);
        check("rt_sticky",  bus.err_sticky, 0);

        // Range boundary
        send_word(encode(LIMIT - 1, enc_st));
        @(negedge clock);
        check("below_range", bus.range_err, 0);
        send_word(encode(LIMIT, enc_st));
        @(negedge clock);
        check("r034_range",  bus.range_err,  1);
        check("r034_rule",   bus.rule_err,   0);
        check("r034_sticky", bus.err_sticky, 1);
        check("r034_data",   bus.data_out,   LIMIT);

        // Saturation
        pulse_clear();
        for (int i = 0; i < CMAX + 2; i++) send_word(enc_st[0] ? 27'h0000003 : 27'h0000004);
        @(negedge clock);
        check("sat_count", bus.err_count, CNT_EN ? CMAX : 0);

        // Clear coinciding with a flagged word reaching the output stage
        @(negedge clock);
        w = enc_st[0] ? 27'h0000003 : 27'h0000004;
        bus.tsv_in    = w;
        bus.tsv_valid = 1'b1;
        for (int j = 0; j < 9; j++) enc_st[j] = w[3*j+2];
        @(negedge clock);
        bus.tsv_valid = 1'b0;
        bus.clear_err = 1'b1;
        @(negedge clock);
        bus.clear_err = 1'b0;
        check("clrflag_count",  bus.err_count,  CNT_EN ? 1 : 0);
        check("clrflag_sticky", bus.err_sticky, 1);
        check("clrflag_rule",   bus.rule_err,   1);

        // Reset with words in flight
        @(negedge clock);
        bus.tsv_in    = 27'h0000004;
        bus.tsv_valid = 1'b1;
        @(negedge clock);
        bus.tsv_in    = 27'h0000004;
        @(posedge clock);
        #3;
        reset_n       = 1'b0;
        bus.tsv_valid = 1'b0;
        enc_st        = '0;
        #1;
        check("r036_valid",  bus.data_valid, 0);
        check("r036_data",   bus.data_out,   0);
        check("r036_rule",   bus.rule_err,   0);
        check("r036_sticky", bus.err_sticky, 0);
        check("r036_count",  bus.err_count,  0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("r036_no_valid", bus.data_valid, 0);
        end
        send_word(27'h0000004);
        @(negedge clock);
        check("r036_first_rule",  bus.rule_err,  1);
        check("r036_first_count", bus.err_count, CNT_EN ? 1 : 0);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
